// File: rtl/div_pkg.sv
// div_pkg: shared state encoding, default width and counter sizing for the sequential divider.
package div_pkg;

    localparam int DW_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    function automatic int cnt_width(input int dw);
        return (dw > 1) ? $clog2(dw) : 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration, shifting in the next dividend bit and subtracting the divisor.
module div_step
    import div_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic [DW-1:0] rem,
    input  logic          quo_msb,
    input  logic [DW-1:0] divisor,
    output logic [DW-1:0] rem_next,
    output logic          q_bit
);

    logic [DW:0] trial;

    // After k iterations rem < 2**k, so rem's MSB is zero whenever this cell is used.
    // The DW+1-bit shifted value therefore equals {1'b0, rem_shifted} and bit DW is the borrow.
    assign trial    = {rem, quo_msb} - {1'b0, divisor};
    assign q_bit    = ~trial[DW];
    assign rem_next = q_bit ? trial[DW-1:0] : {rem[DW-2:0], quo_msb};

endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative unsigned radix-2 restoring divider with valid/ready handshakes on both sides.
module seq_divider
    import div_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_dividend,
    input  logic [DW-1:0] i_divisor,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_quotient,
    output logic [DW-1:0] o_remainder,
    output logic          o_div0
);

    localparam int CW = cnt_width(DW);

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [DW-1:0] quo;
    logic [DW-1:0] rem;
    logic [DW-1:0] divisor;
    logic [DW-1:0] rem_next;
    logic          q_bit;
    logic          accept;
    logic          zero;
    logic          last;

    assign o_ready     = state == IDLE;
    assign accept      = o_ready && i_valid;
    assign zero        = i_divisor == '0;
    assign last        = cnt == CW'(DW - 1);
    assign o_quotient  = quo;
    assign o_remainder = rem;

    div_step #(.DW(DW)) u_step (
        .rem      (rem),
        .quo_msb  (quo[DW-1]),
        .divisor  (divisor),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Leaving DONE waits for o_valid so a divide-by-zero result is presented for at least one cycle.
    always_comb begin
        state_n = state == IDLE ? (i_valid ? (zero ? DONE : CALC) : IDLE)
                : state == CALC ? (last ? DONE : CALC)
                : state == DONE ? ((o_valid && i_ready) ? IDLE : DONE)
                : IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt     <= '0;
            quo     <= '0;
            rem     <= '0;
            divisor <= '0;
            o_div0  <= 1'b0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= (state == CALC && last) || (state == DONE && !(o_valid && i_ready));
            if (accept) begin
                divisor <= i_divisor;
                quo     <= zero ? '1 : i_dividend;
                rem     <= zero ? i_dividend : '0;
                o_div0  <= zero;
                cnt     <= '0;
            end else if (state == CALC) begin
                rem <= rem_next;
                quo <= {quo[DW-2:0], q_bit};
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random division requests checked against plain arithmetic and expected latency.
module tb_seq_divider;

    localparam int DW = 32;

    logic          i_clk = 1'b0;
    logic          i_rstn = 1'b0;
    logic          i_valid = 1'b0;
    logic          i_ready = 1'b0;
    logic [DW-1:0] i_dividend = '0;
    logic [DW-1:0] i_divisor = '0;
    logic          o_ready;
    logic          o_valid;
    logic [DW-1:0] o_quotient;
    logic [DW-1:0] o_remainder;
    logic          o_div0;

    int errors = 0;
    int checks = 0;

    seq_divider #(.DW(DW)) dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_dividend  (i_dividend),
        .i_divisor   (i_divisor),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_quotient  (o_quotient),
        .o_remainder (o_remainder),
        .o_div0      (o_div0)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One request: hold = cycles of backpressure after o_valid, scramble = keep i_valid high with changing operands.
    task automatic run(input logic [DW-1:0] a, input logic [DW-1:0] b, input int hold, input bit scramble);
        logic [DW-1:0] eq;
        logic [DW-1:0] er;
        int            edges;
        int            exp_lat;
        eq      = (b == 0) ? '1 : a / b;
        er      = (b == 0) ? a : a % b;
        exp_lat = (b == 0) ? 2 : DW + 1;
        @(negedge i_clk);
        chk("ready_before", 64'(o_ready), 64'd1);
        i_valid    = 1'b1;
        i_dividend = a;
        i_divisor  = b;
        i_ready    = (hold == 0);
        @(posedge i_clk);
        @(negedge i_clk);
        edges = 1;
        if (!scramble) i_valid = 1'b0;
        while (!o_valid && edges < 100) begin
            if (scramble) begin
                i_dividend = $urandom;
                i_divisor  = $urandom;
                chk("busy_ready", 64'(o_ready), 64'd0);
            end
            @(posedge i_clk);
            @(negedge i_clk);
            edges++;
        end
        chk("latency", 64'(edges), 64'(exp_lat));
        chk("quotient", 64'(o_quotient), 64'(eq));
        chk("remainder", 64'(o_remainder), 64'(er));
        chk("div0", 64'(o_div0), 64'(b == 0));
        chk("ready_in_done", 64'(o_ready), 64'd0);
        for (int k = 0; k < hold; k++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            chk("hold_valid", 64'(o_valid), 64'd1);
            chk("hold_ready", 64'(o_ready), 64'd0);
            chk("hold_quotient", 64'(o_quotient), 64'(eq));
            chk("hold_remainder", 64'(o_remainder), 64'(er));
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        chk("valid_after_hs", 64'(o_valid), 64'd0);
        chk("ready_after_hs", 64'(o_ready), 64'd1);
        i_ready = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        bit            seen;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_quotient", 64'(o_quotient), 64'd0);
        chk("rst_remainder", 64'(o_remainder), 64'd0);
        chk("rst_div0", 64'(o_div0), 64'd0);
        i_rstn = 1'b1;

        run(32'd100, 32'd7, 0, 1'b0);
        run(32'hFFFF_FFFF, 32'd1, 0, 1'b0);
        run(32'd5, 32'd9, 0, 1'b0);
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        run(32'd1234, 32'd0, 0, 1'b0);
        run(32'd10, 32'd3, 0, 1'b0);
        run(32'd1000, 32'd33, 5, 1'b0);
        run(32'd987654, 32'd321, 2, 1'b1);
        run(32'd55, 32'd0, 3, 1'b1);

        // Reset in the middle of a calculation discards it.
        @(negedge i_clk);
        i_valid    = 1'b1;
        i_dividend = 32'd100000;
        i_divisor  = 32'd3;
        i_ready    = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (10) @(negedge i_clk);
        i_rstn = 1'b0;
        #1;
        chk("midrst_valid", 64'(o_valid), 64'd0);
        chk("midrst_ready", 64'(o_ready), 64'd1);
        chk("midrst_quotient", 64'(o_quotient), 64'd0);
        @(negedge i_clk);
        i_rstn = 1'b1;
        seen = 1'b0;
        repeat (DW + 4) begin
            @(negedge i_clk);
            seen |= o_valid;
        end
        chk("midrst_no_result", 64'(seen), 64'd0);
        i_ready = 1'b0;
        run(32'd77, 32'd7, 0, 1'b0);

        for (int n = 0; n < 16; n++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = DW'($urandom_range(1, 15));
                2:       b = $urandom;
                default: b = a >> $urandom_range(0, 31);
            endcase
            run(a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

endmodule
